// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run/pause/clear sequencer for a single-digit display counter.
// A 16-bit prescaler divides Clk by TICK_DIV. While running, each expiry steps
// a modulo-(CNT_MAX+1) up/down digit. en_out and tc are one-cycle registered
// pulses that follow a step; count already holds the new value when they are high.
//
// Optional feature macro: COUNT_SEQ_ONESHOT_EN
//   defined   : a step that would wrap holds the terminal value, pulses en_out/tc
//               and drops the FSM back to IDLE on the same edge.
//   undefined : free-running modulo wrap; the FSM never leaves RUN on its own.
//
// Command priority within a cycle: clear > stop > start.
// State encoding on the state output: 00 IDLE, 01 RUN, 10 PAUSE.

module count_seq_ctrl #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned CNT_MAX  = 9
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       up,
  output logic [3:0] count,
  output logic       en_out,
  output logic       tc,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } fsm_t;

  // Last prescaler value of a period and the terminal digit, sized to their registers.
  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  CNT_TOP    = 4'(CNT_MAX);

  fsm_t        fsm;
  logic [15:0] presc;
  logic [3:0]  step_count;
  logic        step_wrap;
  logic        step_stops;

  // FSM state is a register; expose it directly.
  assign state = fsm;

  // Next digit value and wrap flag for a step taken this cycle.
  always_comb begin
    step_wrap  = 1'b0;
    step_count = count;
    step_stops = 1'b0;
    if (up) begin
      if (count == CNT_TOP) begin
        step_wrap  = 1'b1;
        step_count = 4'd0;
      end else begin
        step_count = count + 4'd1;
      end
    end else begin
      if (count == 4'd0) begin
        step_wrap  = 1'b1;
        step_count = CNT_TOP;
      end else begin
        step_count = count - 4'd1;
      end
    end
`ifdef COUNT_SEQ_ONESHOT_EN
    // A terminal step holds the digit where it is and ends the run.
    if (step_wrap) begin
      step_count = count;
      step_stops = 1'b1;
    end
`endif
  end

  // Sequencer: FSM, prescaler, digit and the registered step pulses.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      fsm    <= IDLE;
      presc  <= 16'd0;
      count  <= 4'd0;
      en_out <= 1'b0;
      tc     <= 1'b0;
    end else if (clear) begin
      // Clear wins over everything, including a step due this cycle.
      fsm    <= IDLE;
      presc  <= 16'd0;
      count  <= 4'd0;
      en_out <= 1'b0;
      tc     <= 1'b0;
    end else begin
      en_out <= 1'b0;
      tc     <= 1'b0;
      case (fsm)
        IDLE: begin
          // Prescaler is already 0 here; counting starts on the cycle after entry.
          if (start) fsm <= RUN;
        end
        RUN: begin
          if (stop) begin
            // Pause holds the partial period so resume continues where it left off.
            fsm <= PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc  <= 16'd0;
            count  <= step_count;
            en_out <= 1'b1;
            tc     <= step_wrap;
            if (step_stops) fsm <= IDLE;
          end else begin
            presc <= presc + 16'd1;
          end
        end
        PAUSE: begin
          if (start) fsm <= RUN;
        end
        default: begin
          fsm   <= IDLE;
          presc <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl with TICK_DIV=4, CNT_MAX=9.
// A behavioural model tracks run state, the phase within a tick period and the
// digit using plain modulo arithmetic; a compare process checks every output on
// every falling edge. Directed scenarios add literal expectations, then a
// randomized phase exercises commands, direction changes and resets.
// Build with +define+COUNT_SEQ_ONESHOT_EN to cover the one-shot variant.

module tb_count_seq_ctrl;

  localparam int TD = 4;
  localparam int CM = 9;

  logic       Clk = 1'b0;
  logic       Resetn, start, stop, clear, up;
  logic [3:0] count;
  logic       en_out, tc;
  logic [1:0] state;

  int checks = 0;
  int passes = 0;

  // model: run mode 0 idle / 1 run / 2 pause, phase within period, digit, pulses
  int m_mode  = 0;
  int m_phase = 0;
  int m_count = 0;
  int m_en    = 0;
  int m_tc    = 0;
  bit cmp_on  = 1'b0;

  count_seq_ctrl #(.TICK_DIV(TD), .CNT_MAX(CM)) dut (
    .Clk(Clk), .Resetn(Resetn), .start(start), .stop(stop), .clear(clear),
    .up(up), .count(count), .en_out(en_out), .tc(tc), .state(state)
  );

  // clock
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reference model, advanced on each rising edge from the sampled inputs
  always @(posedge Clk) begin
    int nxt;
    bit wrap;
    m_en = 0;
    m_tc = 0;
    if (!Resetn || clear) begin
      m_mode = 0; m_phase = 0; m_count = 0;
    end else if (m_mode == 1) begin
      if (stop) m_mode = 2;
      else if (m_phase == TD - 1) begin
        m_phase = 0;
        if (up) begin
          wrap = (m_count == CM);
          nxt  = (m_count + 1) % (CM + 1);
        end else begin
          wrap = (m_count == 0);
          nxt  = (m_count + CM) % (CM + 1);
        end
`ifdef COUNT_SEQ_ONESHOT_EN
        if (wrap) begin
          nxt = m_count;
          m_mode = 0;
        end
`endif
        m_count = nxt;
        m_en = 1;
        m_tc = wrap ? 1 : 0;
      end else m_phase = m_phase + 1;
    end else if (start) m_mode = 1;
  end

  // scoreboard compare, away from the active edge
  always @(negedge Clk) begin
    if (cmp_on) begin
      check("model_count", int'(count), m_count);
      check("model_state", int'(state), m_mode);
      check("model_en", int'(en_out), m_en);
      check("model_tc", int'(tc), m_tc);
    end
  end

  // wait for the next en_out pulse, returning the number of falling edges taken
  task automatic wait_en(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!en_out && n < 60);
    if (!en_out) check("en_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  initial begin
    int n;
    int held;
    Resetn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; up = 1'b1;
    repeat (2) @(negedge Clk);
    cmp_on = 1'b1;
    check("rst_count", int'(count), 0);
    check("rst_state", int'(state), 0);
    check("rst_en", int'(en_out), 0);
    check("rst_tc", int'(tc), 0);
    Resetn = 1'b1;
    @(negedge Clk);

`ifndef COUNT_SEQ_ONESHOT_EN
    // counting up through a full wrap
    up = 1'b1;
    pulse_start();
    check("run_state", int'(state), 1);
    for (int k = 1; k <= 10; k++) begin
      wait_en(n);
      check("up_gap", n, 4);
      check("up_count", int'(count), k % 10);
      check("up_tc", int'(tc), (k == 10) ? 1 : 0);
    end
    // reversing from 0 wraps to 9
    up = 1'b0;
    wait_en(n);
    check("dn_wrap_count", int'(count), 9);
    check("dn_wrap_tc", int'(tc), 1);
    wait_en(n);
    check("dn_count", int'(count), 8);
    check("dn_tc", int'(tc), 0);
    // pause two cycles into a period
    repeat (2) @(negedge Clk);
    stop = 1'b1;
    @(negedge Clk);
    stop = 1'b0;
    check("pause_state", int'(state), 2);
    held = int'(count);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("pause_hold", int'(count), held);
      check("pause_en", int'(en_out), 0);
    end
    pulse_start();
    check("resume_state", int'(state), 1);
    wait_en(n);
    check("resume_gap", n, 2);
    check("resume_count", int'(count), 7);
    // all commands together on the cycle a step is due
    repeat (3) @(negedge Clk);
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    @(negedge Clk);
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    check("clr_state", int'(state), 0);
    check("clr_count", int'(count), 0);
    check("clr_en", int'(en_out), 0);
`else
    // one-shot: counts up to 9 and stops on the terminal step
    up = 1'b1;
    pulse_start();
    check("run_state", int'(state), 1);
    for (int k = 1; k <= 10; k++) begin
      wait_en(n);
      check("os_count", int'(count), (k == 10) ? 9 : k);
      check("os_tc", int'(tc), (k == 10) ? 1 : 0);
      check("os_state", int'(state), (k == 10) ? 0 : 1);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      check("os_no_en", int'(en_out), 0);
    end
    pulse_start();
    wait_en(n);
    check("os_rerun_gap", n, 4);
    check("os_rerun_count", int'(count), 9);
    check("os_rerun_tc", int'(tc), 1);
    check("os_rerun_state", int'(state), 0);
`endif

    // randomized commands, direction and resets
    for (int i = 0; i < 1500; i++) begin
      clear  = ($urandom_range(0, 59) == 0);
      stop   = ($urandom_range(0, 24) == 0);
      start  = ($urandom_range(0, 5) == 0);
      Resetn = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) up = ~up;
      @(negedge Clk);
    end
    Resetn = 1'b1; clear = 1'b0; stop = 1'b0; start = 1'b0;
    @(negedge Clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // hard time limit
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
